// File: rtl/fpu_addsub_param.sv
// Multi-cycle floating-point add/subtract for a generic {sign, exp, mant} format.
// Start/busy/done handshake, G/R/S alignment, one normalisation shift per cycle, RNE.
module fpu_addsub_param #(
  parameter  int EXP_W = 6,
  parameter  int MAN_W = 25,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock100KHz,
  input  logic         reset,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);
  // Internal mantissa layout: {carry, hidden, mant[MAN_W-1:0], G, R, S}
  localparam int M = MAN_W + 5;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [3:0] ST_EXACT   = 4'b0001;
  localparam logic [3:0] ST_INEXACT = 4'b0010;
  localparam logic [3:0] ST_OVF     = 4'b0100;
  localparam logic [3:0] ST_UNF     = 4'b1000;

  typedef enum logic [2:0] {IDLE, ALIGN, OPER, NORM, ROUND} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d, sign_q, sign_d;
  logic [EXP_W-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d, exp_q, exp_d;
  logic [M-1:0]     man_a_q, man_a_d, man_b_q, man_b_d, man_q, man_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [W-1:0]     data_q, data_d;
  logic [3:0]       status_q, status_d;

  function automatic logic [EXP_W-1:0] exp_of(input logic [W-1:0] x);
    return x[W-2 -: EXP_W];
  endfunction

  // A zero exponent means the operand is zero; its stored mantissa is ignored.
  function automatic logic [M-1:0] man_of(input logic [W-1:0] x);
    return (exp_of(x) != '0) ? {2'b01, x[MAN_W-1:0], 3'b000} : '0;
  endfunction

  // Alignment: the smaller-exponent operand is shifted right, lost bits fold into S.
  logic             swap, small_sticky;
  logic [EXP_W-1:0] diff;
  logic [M-1:0]     big_man, small_man, small_sh, small_al;

  always_comb begin
    swap         = exp_b_q > exp_a_q;
    diff         = swap ? (exp_b_q - exp_a_q) : (exp_a_q - exp_b_q);
    big_man      = swap ? man_b_q : man_a_q;
    small_man    = swap ? man_a_q : man_b_q;
    small_sh     = small_man >> diff;
    small_sticky = |(small_man & ~({M{1'b1}} << diff));
    small_al     = {small_sh[M-1:1], small_sh[0] | small_sticky};
  end

  // Round to nearest even on the normalised mantissa.
  logic             rnd_inc, rnd_inexact, rnd_cout, rnd_ovf;
  logic [MAN_W-1:0] rnd_man;
  logic [EXP_W-1:0] rnd_exp, exp_inc;

  always_comb begin
    rnd_inc              = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
    rnd_inexact          = |man_q[2:0];
    {rnd_cout, rnd_man}  = {1'b0, man_q[MAN_W+2:3]} + {{MAN_W{1'b0}}, rnd_inc};
    rnd_exp              = exp_q + {{(EXP_W-1){1'b0}}, rnd_cout};
    rnd_ovf              = ovf_q | (rnd_cout & (rnd_exp == EXP_MAX));
    exp_inc              = exp_q + EXP_ONE;
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    sign_d   = sign_q;
    exp_a_d  = exp_a_q;
    exp_b_d  = exp_b_q;
    exp_d    = exp_q;
    man_a_d  = man_a_q;
    man_b_d  = man_b_q;
    man_d    = man_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    data_d   = data_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        // busy stays high through the done cycle, so a start there is dropped
        busy_d = 1'b0;
        if (start && !busy_q) begin
          busy_d   = 1'b1;
          sign_a_d = op_A_in[W-1];
          sign_b_d = op_B_in[W-1] ^ op_sub;
          exp_a_d  = exp_of(op_A_in);
          exp_b_d  = exp_of(op_B_in);
          man_a_d  = man_of(op_A_in);
          man_b_d  = man_of(op_B_in);
          ovf_d    = (exp_of(op_A_in) == EXP_MAX) | (exp_of(op_B_in) == EXP_MAX);
          unf_d    = 1'b0;
          state_d  = ALIGN;
        end
      end
      ALIGN: begin
        exp_d    = swap ? exp_b_q : exp_a_q;
        man_a_d  = big_man;
        man_b_d  = small_al;
        sign_a_d = swap ? sign_b_q : sign_a_q;
        sign_b_d = swap ? sign_a_q : sign_b_q;
        state_d  = OPER;
      end
      OPER: begin
        if (sign_a_q == sign_b_q) begin
          man_d  = man_a_q + man_b_q;
          sign_d = sign_a_q;
        end else if (man_a_q > man_b_q) begin
          man_d  = man_a_q - man_b_q;
          sign_d = sign_a_q;
        end else if (man_b_q > man_a_q) begin
          man_d  = man_b_q - man_a_q;
          sign_d = sign_b_q;
        end else begin
          man_d  = '0;
          sign_d = 1'b0;
        end
        state_d = NORM;
      end
      NORM: begin
        if (ovf_q || unf_q) begin
          state_d = ROUND;
        end else if (man_q == '0) begin
          sign_d  = 1'b0;
          exp_d   = '0;
          state_d = ROUND;
        end else if (man_q[M-1]) begin
          man_d = {1'b0, man_q[M-1:2], man_q[1] | man_q[0]};
          exp_d = exp_inc;
          if (exp_inc == EXP_MAX) begin
            ovf_d   = 1'b1;
            state_d = ROUND;
          end
        end else if (!man_q[M-2]) begin
          if (exp_q == EXP_ONE) begin
            unf_d   = 1'b1;
            state_d = ROUND;
          end else begin
            man_d = man_q << 1;
            exp_d = exp_q - EXP_ONE;
          end
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (rnd_ovf) begin
          data_d   = '0;
          status_d = ST_OVF;
        end else if (unf_q) begin
          data_d   = '0;
          status_d = ST_UNF;
        end else begin
          data_d   = {sign_q, rnd_exp, rnd_man};
          status_d = rnd_inexact ? ST_INEXACT : ST_EXACT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sign_q   <= 1'b0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      exp_q    <= '0;
      man_a_q  <= '0;
      man_b_q  <= '0;
      man_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      sign_q   <= sign_d;
      exp_a_q  <= exp_a_d;
      exp_b_q  <= exp_b_d;
      exp_q    <= exp_d;
      man_a_q  <= man_a_d;
      man_b_q  <= man_b_d;
      man_q    <= man_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign data_out   = data_q;
  assign status_out = status_q;
endmodule

// File: tb/tb_fpu_addsub_param.sv
// Bench for fpu_addsub_param: directed cases plus random operands against an
// exact-arithmetic reference model; a second instance covers the 1/8/23 format.
module tb_fpu_addsub_param;
  logic        clk, rst_n;
  logic        start, op_sub;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] dout;
  logic [3:0]  st;

  logic        start2, op_sub2;
  logic [31:0] a2, b2;
  logic        busy2, done2;
  logic [31:0] dout2;
  logic [3:0]  st2;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_addsub_param dut (
    .clock100KHz(clk), .reset(rst_n), .start(start), .op_sub(op_sub),
    .op_A_in(a), .op_B_in(b), .busy(busy), .done(done),
    .data_out(dout), .status_out(st)
  );

  fpu_addsub_param #(.EXP_W(8), .MAN_W(23)) dut2 (
    .clock100KHz(clk), .reset(rst_n), .start(start2), .op_sub(op_sub2),
    .op_A_in(a2), .op_B_in(b2), .busy(busy2), .done(done2),
    .data_out(dout2), .status_out(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact value of each operand is sig * 2^exp; sum computed exactly, then rounded RNE.
  function automatic void ref_model(input logic [31:0] ia, input logic [31:0] ib,
                                    input logic isub, output logic [31:0] r,
                                    output logic [3:0] s);
    int ea, eb, elo, p, e, drop;
    logic sa, sb, sr, inex;
    logic [127:0] x, y, mag, q, rem, half;
    ea = int'(ia[30:25]);
    eb = int'(ib[30:25]);
    sa = ia[31];
    sb = ib[31] ^ isub;
    r  = '0;
    s  = 4'b0001;
    sr = 1'b0;
    if (ea == 63 || eb == 63) begin s = 4'b0100; return; end
    x = (ea != 0) ? ((128'd1 << 25) | 128'(ia[24:0])) : 128'd0;
    y = (eb != 0) ? ((128'd1 << 25) | 128'(ib[24:0])) : 128'd0;
    elo = (ea < eb) ? ea : eb;
    x = x << (ea - elo);
    y = y << (eb - elo);
    if (sa == sb) begin mag = x + y; sr = sa; end
    else if (x > y) begin mag = x - y; sr = sa; end
    else if (y > x) begin mag = y - x; sr = sb; end
    else mag = '0;
    if (mag == 0) return;
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = elo + p - 25;
    if (e < 1) begin s = 4'b1000; return; end
    inex = 1'b0;
    if (p > 25) begin
      drop = p - 25;
      q    = mag >> drop;
      rem  = mag & ((128'd1 << drop) - 128'd1);
      half = 128'd1 << (drop - 1);
      inex = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 128'd1;
      if (q[26]) begin q = q >> 1; e++; end
    end else begin
      q = mag << (25 - p);
    end
    if (e >= 63) begin s = 4'b0100; return; end
    r = {sr, 6'(e), q[24:0]};
    s = inex ? 4'b0010 : 4'b0001;
  endfunction

  // Drives one operation on dut; cyc = edges from acceptance to done, -1 on timeout.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                        output logic [31:0] rd, output logic [3:0] rs, output int cyc);
    cyc = -1;
    for (int i = 0; i < 300 && busy; i++) begin @(posedge clk); #1; end
    @(negedge clk);
    a = ia; b = ib; op_sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op_sub = 1'($urandom);
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done) begin cyc = i; break; end
    end
    rd = dout;
    rs = st;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    start2 = 1'b0; op_sub2 = 1'b0; a2 = '0; b2 = '0;
    #12;
    n_tests++;
    if ({busy, done, dout, st} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b data=%h status=%b, required all 0",
               busy, done, dout, st);
    end
    n_tests++;
    if ({busy2, done2, dout2, st2} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_state_p8: busy=%b done=%b data=%h status=%b, required all 0",
               busy2, done2, dout2, st2);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_add;
    logic [31:0] ia[3] = '{32'h40000000, 32'h40000000, 32'h40000000};
    logic [31:0] ib[3] = '{32'h42000000, 32'h40000000, 32'h40000000};
    logic        sb[3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] ed[3] = '{32'h43000000, 32'h42000000, 32'h00000000};
    int          ec[3] = '{4, 5, 5};
    logic [31:0] rd; logic [3:0] rs; int cyc;
    for (int i = 0; i < 3; i++) begin
      run_op(ia[i], ib[i], sb[i], rd, rs, cyc);
      n_tests++;
      if (rd !== ed[i] || rs !== 4'b0001) begin
        n_fail++;
        $display("FAIL add_%0d: got %h/%b, required %h/0001", i, rd, rs, ed[i]);
      end
      n_tests++;
      if (i < 2 && cyc != ec[i]) begin
        n_fail++;
        $display("FAIL add_latency_%0d: got %0d cycles, required %0d", i, cyc, ec[i]);
      end else if (i == 2 && cyc < 0) begin
        n_fail++;
        $display("FAIL add_latency_%0d: no done within bound", i);
      end
    end
  endtask

  task automatic test_rounding;
    logic [31:0] ia[3] = '{32'h40000000, 32'h40000001, 32'h40000000};
    logic [31:0] ib[3] = '{32'h0A000000, 32'h0C000000, 32'h0C000000};
    logic [31:0] ed[3] = '{32'h40000000, 32'h40000002, 32'h40000000};
    logic [31:0] rd; logic [3:0] rs; int cyc;
    for (int i = 0; i < 3; i++) begin
      run_op(ia[i], ib[i], 1'b0, rd, rs, cyc);
      n_tests++;
      if (cyc < 0 || rd !== ed[i] || rs !== 4'b0010) begin
        n_fail++;
        $display("FAIL round_%0d: got %h/%b cyc=%0d, required %h/0010", i, rd, rs, cyc, ed[i]);
      end
    end
  endtask

  task automatic test_exceptions;
    logic [31:0] ia[3] = '{32'h7C000000, 32'h02000001, 32'h7E000000};
    logic [31:0] ib[3] = '{32'h7C000000, 32'h02000000, 32'h40000000};
    logic        sb[3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0]  es[3] = '{4'b0100, 4'b1000, 4'b0100};
    logic [31:0] rd; logic [3:0] rs; int cyc;
    for (int i = 0; i < 3; i++) begin
      run_op(ia[i], ib[i], sb[i], rd, rs, cyc);
      n_tests++;
      if (cyc < 0 || rd !== 32'h0 || rs !== es[i]) begin
        n_fail++;
        $display("FAIL exception_%0d: got %h/%b cyc=%0d, required 00000000/%b", i, rd, rs, cyc, es[i]);
      end
    end
  endtask

  task automatic test_long_norm;
    logic [31:0] rd; logic [3:0] rs; int cyc;
    run_op(32'h40000001, 32'h40000000, 1'b1, rd, rs, cyc);
    n_tests++;
    if (rd !== 32'h0E000000 || rs !== 4'b0001 || cyc != 29) begin
      n_fail++;
      $display("FAIL long_norm: got %h/%b cyc=%0d, required 0E000000/0001 cyc=29", rd, rs, cyc);
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    logic [31:0] first = '0;
    for (int i = 0; i < 300 && busy; i++) begin @(posedge clk); #1; end
    @(negedge clk);
    a = 32'h40000000; b = 32'h42000000; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 2) begin a = 32'h40000000; b = 32'h40000000; start = 1'b1; end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first = dout;
          a = 32'h40000000; b = 32'h40000000; start = 1'b1;
        end
      end
    end
    n_tests++;
    if (ndone != 1 || first !== 32'h43000000) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d dones data=%h, required 1 done data=43000000", ndone, first);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_random;
    logic [31:0] ia, ib, rd, ed; logic [3:0] rs, es; logic sb; int cyc, ea, eb, off;
    for (int n = 0; n < 300; n++) begin
      ea  = $urandom_range(62, 1);
      off = ($urandom_range(9, 0) < 7) ? $urandom_range(6, 0) - 3 : $urandom_range(70, 0) - 35;
      eb  = ea + off;
      if (eb < 0) eb = 0;
      if (eb > 63) eb = 63;
      ia  = {1'($urandom), 6'(ea), 25'($urandom)};
      ib  = {1'($urandom), 6'(eb), 25'($urandom)};
      sb  = 1'($urandom);
      ref_model(ia, ib, sb, ed, es);
      run_op(ia, ib, sb, rd, rs, cyc);
      n_tests++;
      if (cyc < 0 || rd !== ed || rs !== es) begin
        n_fail++;
        $display("FAIL random_%0d: %h %s %h got %h/%b cyc=%0d, required %h/%b",
                 n, ia, sb ? "-" : "+", ib, rd, rs, cyc, ed, es);
      end
    end
  endtask

  task automatic test_param_sweep;
    int cyc = -1;
    @(negedge clk);
    a2 = 32'h40000000; b2 = 32'h40000000; op_sub2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done2) begin cyc = i; break; end
    end
    n_tests++;
    if (cyc != 5 || dout2 !== 32'h40800000 || st2 !== 4'b0001) begin
      n_fail++;
      $display("FAIL param_sweep: got %h/%b cyc=%0d, required 40800000/0001 cyc=5", dout2, st2, cyc);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic [3:0] rs; int cyc; int ndone = 0;
    run_op(32'h40000000, 32'h42000000, 1'b0, rd, rs, cyc);
    @(negedge clk);
    a = 32'h40000001; b = 32'h40000000; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, dout, st} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b data=%h status=%b, required all 0",
               busy, done, dout, st);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_tests++;
    if (ndone != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got %0d dones busy=%b, required 0 dones busy=0", ndone, busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_rounding();
    test_exceptions();
    test_long_norm();
    test_back_to_back();
    test_random();
    test_param_sweep();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
